// File: rtl/jkdrv_pkg.sv
// Shared types and constants for the JK pattern driver.
// The state encoding is also exported on the debug port of the interface.
package jkdrv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2
    } state_t;

    // JK excitation pairs, packed as {J, K}.
    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] SET  = 2'b10;
    localparam logic [1:0] CLR  = 2'b01;

endpackage

// File: rtl/jk_pattern_driver_if.sv
// Bus between the JK pattern driver and its requester / downstream flip-flop.
//
// Handshake: a play request is start=1 seen at a rising edge while busy=0.
// That edge captures pattern. While busy=1, start is ignored: it is neither
// re-captured nor does it extend a run. done pulses for one cycle at the end
// of a run. busy therefore acts as the inverted ready for start.
//
// dbg_state and dbg_qm expose the FSM state and the shadow Q bit for
// checkers. They are not part of the functional interface.
interface jk_pattern_driver_if #(
    parameter int WIDTH = 8
);
    import jkdrv_pkg::*;

    logic             start;
    logic [WIDTH-1:0] pattern;
    logic             j;
    logic             k;
    logic             q_fb;
    logic             busy;
    logic             done;
    logic             mismatch;
    state_t           dbg_state;
    logic             dbg_qm;

    modport master (
        output start, pattern, q_fb,
        input  j, k, busy, done, mismatch, dbg_state, dbg_qm
    );

    modport slave (
        input  start, pattern, q_fb,
        output j, k, busy, done, mismatch, dbg_state, dbg_qm
    );

endinterface

// File: rtl/jk_excite.sv
// JK excitation: picks the {J, K} pair that moves the flip-flop from qm to t.
// J=K=1 (toggle) is never produced.
module jk_excite
    import jkdrv_pkg::*;
(
    input  logic qm,
    input  logic t,
    output logic j,
    output logic k
);

    logic [1:0] jk;

    // Hold when the target already matches the current value,
    // otherwise set or clear toward the target.
    always_comb begin
        jk = HOLD;
        if (qm != t) begin
            jk = t ? SET : CLR;
        end
    end

    assign j = jk[1];
    assign k = jk[0];

endmodule

// File: rtl/jk_pattern_driver.sv
// JK pattern driver.
// The driver replays a captured WIDTH-bit pattern, LSB first, as the Q
// sequence of a downstream JK flip-flop. For each bit it drives J/K from a
// shadow model (qm) of the flip-flop. A run is WIDTH RUN cycles followed by
// one CHECK cycle, in which done is high.
//
// Optional feature: when JKDRV_QCHECK_EN is defined, q_fb is compared with
// qm in every RUN and CHECK cycle. Any disagreement sets the sticky mismatch
// flag. When the macro is undefined, mismatch is tied low.
module jk_pattern_driver
    import jkdrv_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    jk_pattern_driver_if.slave bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] cnt;
    logic             qm;
    logic             t;
    logic             last_bit;
    logic             start_acc;
    logic             ex_j;
    logic             ex_k;
    logic             j_out;
    logic             k_out;
    logic             busy_out;
    logic             done_out;
    logic             mismatch_q;

    assign t        = sreg[0];
    assign last_bit = (cnt == CNT_LAST);

    jk_excite u_excite (
        .qm (qm),
        .t  (t),
        .j  (ex_j),
        .k  (ex_k)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the J/K/busy/done outputs.
    // J/K are forced to hold outside RUN.
    always_comb begin
        next_state = state;
        start_acc  = 1'b0;
        j_out      = 1'b0;
        k_out      = 1'b0;
        busy_out   = 1'b0;
        done_out   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    start_acc  = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                busy_out = 1'b1;
                j_out    = ex_j;
                k_out    = ex_k;
                if (last_bit) begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                busy_out   = 1'b1;
                done_out   = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Pattern shift register, bit counter and shadow Q.
    // qm is kept between runs. The counter stops at WIDTH-1 and does not wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg <= '0;
            cnt  <= '0;
            qm   <= 1'b0;
        end else if (start_acc) begin
            sreg <= bus.pattern;
            cnt  <= '0;
        end else if (state == RUN) begin
            qm   <= t;
            sreg <= sreg >> 1;
            if (!last_bit) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef JKDRV_QCHECK_EN
    // Sticky feedback check. It is cleared by reset or by an accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            mismatch_q <= 1'b0;
        end else if (start_acc) begin
            mismatch_q <= 1'b0;
        end else if ((state != IDLE) && (bus.q_fb != qm)) begin
            mismatch_q <= 1'b1;
        end
    end
`else
    logic unused_q_fb;
    assign unused_q_fb = bus.q_fb;
    assign mismatch_q  = 1'b0;
`endif

    assign bus.j         = j_out;
    assign bus.k         = k_out;
    assign bus.busy      = busy_out;
    assign bus.done      = done_out;
    assign bus.mismatch  = mismatch_q;
    assign bus.dbg_state = state;
    assign bus.dbg_qm    = qm;

endmodule

// File: tb/tb_jk_pattern_driver.sv
// Testbench for jk_pattern_driver. A behavioural JK flip-flop closes the
// q_fb loop, and it can be overridden to force q_fb low.
// Per-cycle expectations are packed as {state, busy, done, j, k, qm}.
module tb_jk_pattern_driver;
    import jkdrv_pkg::*;

    localparam int WIDTH = 8;
`ifdef JKDRV_QCHECK_EN
    localparam bit QCHK = 1'b1;
`else
    localparam bit QCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ff_q;
    logic force_q0 = 1'b0;
    logic model_qm = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [6:0] exp_q[$];

    always #5 clk = ~clk;

    jk_pattern_driver_if #(.WIDTH(WIDTH)) bus ();

    jk_pattern_driver #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Downstream JK flip-flop, sharing the driver's reset.
    always @(posedge clk) begin
        if (reset) ff_q <= 1'b0;
        else begin
            case ({bus.j, bus.k})
                2'b10: ff_q <= 1'b1;
                2'b01: ff_q <= 1'b0;
                2'b11: ff_q <= ~ff_q;
                default: ff_q <= ff_q;
            endcase
        end
    end

    assign bus.q_fb = force_q0 ? 1'b0 : ff_q;

    function automatic logic [6:0] actual();
        return {bus.dbg_state, bus.busy, bus.done, bus.j, bus.k, bus.dbg_qm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue the expected behaviour of one full run of pat, starting from model_qm.
    task automatic push_run(input logic [WIDTH-1:0] pat);
        logic       tb;
        logic [1:0] jk;
        for (int i = 0; i < WIDTH; i++) begin
            tb = pat[i];
            if (model_qm == tb) jk = 2'b00;
            else if (tb)        jk = 2'b10;
            else                jk = 2'b01;
            exp_q.push_back({RUN, 1'b1, 1'b0, jk, model_qm});
            model_qm = tb;
        end
        exp_q.push_back({CHECK, 1'b1, 1'b1, 2'b00, model_qm});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        step();
        step();
        reset = 1'b0;
        model_qm = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [6:0] exp;
        do_reset();
        for (int c = 0; c < 2; c++) begin
            exp = {IDLE, 5'b0};
            checks++;
            if (actual() !== exp) begin
                errors++;
                $display("FAIL reset_outputs c%0d act=%b exp=%b", c, actual(), exp);
            end
            checks++;
            if (bus.mismatch !== 1'b0) begin
                errors++;
                $display("FAIL reset_mismatch act=%b exp=0", bus.mismatch);
            end
            step();
        end
    endtask

    task automatic test_basic();
        logic [1:0] jk_tab [WIDTH];
        logic       q_tab  [WIDTH];
        logic [6:0] exp;
        jk_tab = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01, 2'b10};
        q_tab  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        bus.pattern = 8'b1010_0110;
        bus.start = 1'b1;
        push_run(bus.pattern);
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= WIDTH + 1; c++) begin
            exp = exp_q.pop_front();
            checks++;
            if (actual() !== exp) begin
                errors++;
                $display("FAIL basic_cycle%0d act=%b exp=%b", c, actual(), exp);
            end
            if (c <= WIDTH) begin
                checks++;
                if ({bus.j, bus.k} !== jk_tab[c-1]) begin
                    errors++;
                    $display("FAIL basic_jk%0d act=%b exp=%b", c, {bus.j, bus.k}, jk_tab[c-1]);
                end
            end
            if (c >= 2) begin
                checks++;
                if (ff_q !== q_tab[c-2]) begin
                    errors++;
                    $display("FAIL basic_ffq%0d act=%b exp=%b", c, ff_q, q_tab[c-2]);
                end
            end
            checks++;
            if (bus.mismatch !== 1'b0) begin
                errors++;
                $display("FAIL basic_mismatch%0d act=%b exp=0", c, bus.mismatch);
            end
            step();
        end
        checks++;
        if ({ff_q, bus.dbg_state, bus.busy} !== {q_tab[WIDTH-1], IDLE, 1'b0}) begin
            errors++;
            $display("FAIL basic_end act=%b/%0d/%b exp=%b/IDLE/0", ff_q, bus.dbg_state, bus.busy, q_tab[WIDTH-1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp;
        int jcnt = 0;
        int kcnt = 0;
        logic j_first = 1'b0;
        logic k_first = 1'b0;
        do_reset();
        bus.pattern = 8'hFF;
        bus.start = 1'b1;
        push_run(bus.pattern);
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= WIDTH + 1; c++) begin
            exp = exp_q.pop_front();
            checks++;
            if (actual() !== exp) begin
                errors++;
                $display("FAIL b2b_run1_cycle%0d act=%b exp=%b", c, actual(), exp);
            end
            if (bus.j) jcnt++;
            if (c == 1) j_first = bus.j;
            step();
        end
        bus.pattern = 8'h00;
        bus.start = 1'b1;
        push_run(bus.pattern);
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= WIDTH + 1; c++) begin
            exp = exp_q.pop_front();
            checks++;
            if (actual() !== exp) begin
                errors++;
                $display("FAIL b2b_run2_cycle%0d act=%b exp=%b", c, actual(), exp);
            end
            if (bus.k) kcnt++;
            if (c == 1) k_first = bus.k;
            step();
        end
        checks++;
        if ({jcnt, kcnt, j_first, k_first} !== {32'd1, 32'd1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL b2b_pulses act=j%0d k%0d jf%b kf%b exp=j1 k1 jf1 kf1", jcnt, kcnt, j_first, k_first);
        end
        checks++;
        if (bus.dbg_qm !== 1'b0) begin
            errors++;
            $display("FAIL b2b_qm_end act=%b exp=0", bus.dbg_qm);
        end
    endtask

    task automatic test_start_held();
        logic [WIDTH-1:0] pat;
        logic [WIDTH-1:0] pat2;
        logic [6:0] exp;
        int busy_cnt = 0;
        int done_cnt = 0;
        do_reset();
        pat  = WIDTH'($urandom_range(1, 254));
        pat2 = WIDTH'($urandom_range(1, 254));
        bus.pattern = pat;
        bus.start = 1'b1;
        push_run(pat);
        step();
        for (int c = 1; c <= WIDTH + 1; c++) begin
            if (c == 3) bus.pattern = ~pat;
            exp = exp_q.pop_front();
            checks++;
            if (actual() !== exp) begin
                errors++;
                $display("FAIL held_cycle%0d act=%b exp=%b", c, actual(), exp);
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) done_cnt++;
            step();
        end
        checks++;
        if ({busy_cnt, done_cnt, bus.busy, bus.dbg_state} !== {32'd9, 32'd1, 1'b0, IDLE}) begin
            errors++;
            $display("FAIL held_counts act=busy%0d done%0d b%b s%0d exp=busy9 done1 b0 IDLE", busy_cnt, done_cnt, bus.busy, bus.dbg_state);
        end
        bus.pattern = pat2;
        push_run(pat2);
        step();
        exp = exp_q.pop_front();
        checks++;
        if (actual() !== exp) begin
            errors++;
            $display("FAIL held_recapture act=%b exp=%b", actual(), exp);
        end
        bus.start = 1'b0;
        do_reset();
    endtask

    task automatic test_reset_mid_run();
        logic [6:0] exp;
        int done_cnt = 0;
        int busy_cnt = 0;
        do_reset();
        bus.pattern = 8'hA5;
        bus.start = 1'b1;
        push_run(bus.pattern);
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            exp = exp_q.pop_front();
            checks++;
            if (actual() !== exp) begin
                errors++;
                $display("FAIL abort_cycle%0d act=%b exp=%b", c, actual(), exp);
            end
            if (c < 4) step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_qm = 1'b0;
        exp_q.delete();
        exp = {IDLE, 5'b0};
        checks++;
        if (actual() !== exp) begin
            errors++;
            $display("FAIL abort_after act=%b exp=%b", actual(), exp);
        end
        for (int c = 0; c < WIDTH + 2; c++) begin
            if (bus.done) done_cnt++;
            if (bus.busy) busy_cnt++;
            step();
        end
        checks++;
        if ({done_cnt, busy_cnt} !== {32'd0, 32'd0}) begin
            errors++;
            $display("FAIL abort_no_done act=done%0d busy%0d exp=0 0", done_cnt, busy_cnt);
        end
    endtask

    task automatic test_start_reset_same();
        reset = 1'b1;
        bus.start = 1'b1;
        bus.pattern = WIDTH'($urandom_range(1, 255));
        step();
        reset = 1'b0;
        bus.start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if ({bus.dbg_state, bus.busy} !== {IDLE, 1'b0}) begin
                errors++;
                $display("FAIL start_reset_c%0d act=%0d/%b exp=IDLE/0", c, bus.dbg_state, bus.busy);
            end
            step();
        end
        model_qm = 1'b0;
    endtask

    task automatic test_mismatch();
        logic exp_mm;
        do_reset();
        force_q0 = 1'b1;
        bus.pattern = 8'h02;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= WIDTH + 2; c++) begin
            exp_mm = QCHK && (c >= 4);
            checks++;
            if (bus.mismatch !== exp_mm) begin
                errors++;
                $display("FAIL mismatch_c%0d act=%b exp=%b", c, bus.mismatch, exp_mm);
            end
            if (c <= WIDTH + 1) step();
        end
        bus.pattern = 8'h00;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++;
        if ({bus.mismatch, bus.busy} !== 2'b01) begin
            errors++;
            $display("FAIL mismatch_clear act=mm%b busy%b exp=mm0 busy1", bus.mismatch, bus.busy);
        end
        force_q0 = 1'b0;
        do_reset();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.pattern = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_start_held();
        test_reset_mid_run();
        test_start_reset_same();
        test_mismatch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_pattern_driver.md
JK_PATTERN_DRIVER -- requirements
Module: jk_pattern_driver

Interface
REQ-001 Parameter: WIDTH, default 8, pattern length in bits (>=2).
REQ-002 Clk  input  1  single clock; all state changes on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset; shared with the driven JK flip-flop.
REQ-004 Start  input  1  request to play Pattern; sampled only in IDLE.
REQ-005 Pattern  input  WIDTH  target Q sequence, LSB played first; captured when Start accepted.
REQ-006 J  output  1  J drive to downstream JK flip-flop.
REQ-007 K  output  1  K drive to downstream JK flip-flop.
REQ-008 Q_fb  input  1  Q returned from the downstream flip-flop (used only with check feature).
REQ-009 Busy  output  1  high in RUN and CHECK.
REQ-010 Done  output  1  one-cycle pulse, high during CHECK.
REQ-011 Mismatch  output  1  sticky Q_fb vs model disagreement flag.

Function
REQ-012 States: IDLE, RUN, CHECK; RUN lasts exactly WIDTH cycles, CHECK exactly 1 cycle, then IDLE.
REQ-013 IDLE: Start=1 at an edge captures Pattern into shift register, clears bit counter, enters RUN; Start=0 stays IDLE.
REQ-014 Start is ignored in RUN and CHECK (no re-capture, no extension).
REQ-015 Internal shadow bit Qm models the flip-flop; target bit T = current LSB of shift register in RUN.
REQ-016 RUN J/K combinational from Qm and T: Qm==T -> J=0,K=0; Qm=0,T=1 -> J=1,K=0; Qm=1,T=0 -> J=0,K=1; J=K=1 never driven.
REQ-017 Each RUN edge: Qm<=T, shift register shifts right, counter increments; counter==WIDTH-1 at edge -> CHECK.
REQ-018 IDLE and CHECK: J=0, K=0; Qm holds across runs.
REQ-019 Timing: Start sampled at edge e0 -> RUN cycles 1..WIDTH -> CHECK cycle WIDTH+1 (Done=1) -> IDLE cycle WIDTH+2, where Start is accepted again.
REQ-020 Counter width $clog2(WIDTH); no wrap beyond WIDTH-1.

Reset
REQ-021 Reset=1 at an edge: state IDLE, Qm=0, counter=0, shift register=0, Mismatch=0; outputs J=K=Busy=Done=0 next cycle.
REQ-022 Reset wins over Start in the same cycle and aborts RUN/CHECK mid-operation with no Done pulse.

Configuration
REQ-023 Macro JKDRV_QCHECK_EN defined: in every RUN and CHECK cycle Q_fb!=Qm sets Mismatch at that edge; Mismatch cleared only by Reset or accepted Start.
REQ-024 Macro JKDRV_QCHECK_EN undefined: Mismatch tied 0, Q_fb unused, no compare logic.

Structure
REQ-025 Package jkdrv_pkg holds state enum (IDLE, RUN, CHECK) and J/K excitation constants (HOLD=2'b00, SET=2'b10, CLR=2'b01).
REQ-026 Sub-module jk_excite: combinational (Qm, T) -> (J, K) per REQ-016; instantiated once.

Verification
REQ-027 Reset, Pattern=8'b1010_0110, Start 1 cycle -> RUN J/K per cycle: 00,10,00,01,00,10,01,10; Done in cycle 9; with real JK flip-flop Q follows 0,1,1,0,0,1,0,1; Mismatch=0.
REQ-028 Pattern=8'hFF then 8'h00 back-to-back -> run 1: J=1 only in RUN cycle 1; run 2: K=1 only in RUN cycle 1; Qm ends 0.
REQ-029 Start held high through RUN -> single Done pulse, Busy exactly 9 cycles, then immediate re-capture in IDLE.
REQ-030 Reset asserted in RUN cycle 4 -> next cycle IDLE, J=K=Busy=0, Qm=0, no Done.
REQ-031 JKDRV_QCHECK_EN defined, Q_fb forced 0, Pattern=8'h02 -> Mismatch rises at edge ending RUN cycle 3, stays 1 through Done, clears on next accepted Start.
REQ-032 Start and Reset high in same cycle -> remains IDLE, Busy=0.
